// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - control and address lines of the SRAM port
interface sram_responder_if;
  logic [4:0]  sram_control;
  logic [17:0] sram_addr;

  modport master (output sram_control, output sram_addr);
  modport slave  (input  sram_control, input  sram_addr);
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - block-RAM stand-in for the board SRAM with protocol checks and counters
// Optional macro: SRAM_RESP_RANGE_CHECK_EN traps accesses above the implemented depth.
module sram_responder #(
  parameter int ADDR_BITS    = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  sram_responder_if.slave bus,
  inout  wire  [15:0]     sram_data,
  output logic            busy,
  output logic [15:0]     write_count,
  output logic [7:0]      err_count
);
  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state;

  logic ce, oe, we, ub, lb;
  assign {ce, oe, we, ub, lb} = ~bus.sram_control;

  logic [17:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] dout;
  logic        ub_q, lb_q, drive_en;
  logic [1:0]  lat_cnt;
  logic [15:0] mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] idx_q;
  assign idx_q = addr_q[ADDR_BITS-1:0];

  logic addr_moved, hi_bad_in, hi_bad_q;
`ifdef SRAM_RESP_RANGE_CHECK_EN
  assign hi_bad_in  = (bus.sram_addr >> ADDR_BITS) != 18'd0;
  assign hi_bad_q   = (addr_q >> ADDR_BITS) != 18'd0;
  assign addr_moved = bus.sram_addr != addr_q;
`else
  // Upper address bits alias onto the implemented depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.sram_addr >> ADDR_BITS, addr_q >> ADDR_BITS};
  assign hi_bad_in  = 1'b0;
  assign hi_bad_q   = 1'b0;
  assign addr_moved = bus.sram_addr[ADDR_BITS-1:0] != idx_q;
`endif

  logic wr_hold, commit, latch_new;
  assign wr_hold = ce && we;
  // An address change under a held WE commits the old word just like a WE release.
  assign commit  = (state == WRITE) && (!wr_hold || addr_moved);
  assign latch_new = wr_hold ? ((state != WRITE) || addr_moved)
                             : (ce && oe && ((state == IDLE) || ((state == READ) && addr_moved)));

  logic [1:0] err_inc;
  logic [8:0] err_sum;
  assign err_inc = 2'(ce && oe && we) + 2'((state == WRITE) && wr_hold && addr_moved)
                 + 2'(latch_new && hi_bad_in);
  assign err_sum = {1'b0, err_count} + {7'd0, err_inc};

  logic [15:0] mem_word, rd_word;
  assign mem_word = mem[idx_q];
  assign rd_word  = hi_bad_q ? 16'hDEAD
                             : {ub ? mem_word[15:8] : 8'h00, lb ? mem_word[7:0] : 8'h00};

  always_ff @(posedge clk) begin
    if (commit && !hi_bad_q) begin
      if (ub_q) mem[idx_q][15:8] <= wdata_q[15:8];
      if (lb_q) mem[idx_q][7:0]  <= wdata_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ub_q        <= 1'b0;
      lb_q        <= 1'b0;
      lat_cnt     <= '0;
      drive_en    <= 1'b0;
      dout        <= '0;
      write_count <= '0;
      err_count   <= '0;
    end else begin
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (commit && !hi_bad_q) write_count <= write_count + 16'd1;

      unique case (state)
        IDLE: begin
          if (wr_hold) begin
            state   <= WRITE;
            busy    <= 1'b1;
            addr_q  <= bus.sram_addr;
            wdata_q <= sram_data;
            ub_q    <= ub;
            lb_q    <= lb;
          end else if (ce && oe) begin
            state   <= READ;
            busy    <= 1'b1;
            addr_q  <= bus.sram_addr;
            lat_cnt <= 2'd1;
          end
        end
        WRITE: begin
          if (wr_hold) begin
            addr_q  <= bus.sram_addr;
            wdata_q <= sram_data;
            ub_q    <= ub;
            lb_q    <= lb;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        READ: begin
          if (wr_hold) begin
            state    <= WRITE;
            drive_en <= 1'b0;
            addr_q   <= bus.sram_addr;
            wdata_q  <= sram_data;
            ub_q     <= ub;
            lb_q     <= lb;
          end else if (ce && oe) begin
            if (addr_moved) begin
              addr_q   <= bus.sram_addr;
              lat_cnt  <= 2'd1;
              drive_en <= 1'b0;
            end else if (lat_cnt >= LAT) begin
              dout     <= rd_word;
              drive_en <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            drive_en <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

  assign sram_data = drive_en ? dout : 16'hzzzz;
endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - randomized self-checking bench for sram_responder against a word-level model
module tb_sram_responder;
  localparam int AB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  sram_responder_if bus1 ();
  sram_responder_if bus3 ();
  tri1 [15:0] data1;
  tri1 [15:0] data3;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wdata = 16'h0000;
  assign data1 = tb_drv ? tb_wdata : 16'hzzzz;
  assign data3 = tb_drv ? tb_wdata : 16'hzzzz;
  assign bus3.sram_control = bus1.sram_control;
  assign bus3.sram_addr    = bus1.sram_addr;

  logic        busy1, unused_busy3;
  logic [15:0] wc1, unused_wc3;
  logic [7:0]  err1, unused_err3;

  sram_responder #(.ADDR_BITS(AB), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .sram_data(data1),
    .busy(busy1), .write_count(wc1), .err_count(err1));
  sram_responder #(.ADDR_BITS(AB), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3), .sram_data(data3),
    .busy(unused_busy3), .write_count(unused_wc3), .err_count(unused_err3));

  logic [15:0] mm [int];
  int exp_wc = 0, exp_err = 0;
  int total = 0, bad = 0;

  task automatic step(); @(posedge clk); #1; endtask
  task automatic bus_idle(); bus1.sram_control = 5'b11111; tb_drv = 1'b0; endtask
  function automatic logic [4:0] ctl(input bit oe, input bit we, input bit ub, input bit lb);
    return {1'b0, ~oe, ~we, ~ub, ~lb};
  endfunction
  function automatic bit addr_hi(input logic [17:0] a); return (a >> AB) != 18'd0; endfunction
  task automatic bump_err(input int n); exp_err = (exp_err + n > 255) ? 255 : exp_err + n; endtask

  task automatic model_write(input logic [17:0] a, input logic [15:0] d, input bit ub, input bit lb);
    logic [15:0] w;
    int idx;
`ifdef SRAM_RESP_RANGE_CHECK_EN
    if (addr_hi(a)) begin bump_err(1); return; end
`endif
    idx = int'(a) % (1 << AB);
    w = mm.exists(idx) ? mm[idx] : 16'h0000;
    if (ub) w[15:8] = d[15:8];
    if (lb) w[7:0] = d[7:0];
    if (ub || lb) mm[idx] = w;
    exp_wc = (exp_wc + 1) % 65536;
  endtask

  task automatic model_read(input logic [17:0] a, input bit ub, input bit lb, output logic [15:0] e);
    logic [15:0] w;
`ifdef SRAM_RESP_RANGE_CHECK_EN
    if (addr_hi(a)) begin bump_err(1); e = 16'hDEAD; return; end
`endif
    w = mm[int'(a) % (1 << AB)];
    e = {ub ? w[15:8] : 8'h00, lb ? w[7:0] : 8'h00};
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input bit ub, input bit lb, input int hold);
    bus1.sram_addr = a;
    bus1.sram_control = ctl(1'b0, 1'b1, ub, lb);
    tb_drv = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tb_wdata = (k == hold - 1) ? d : 16'($urandom);
      step();
    end
    bus_idle();
    step();
    model_write(a, d, ub, lb);
  endtask

  task automatic do_read(input logic [17:0] a, input bit ub, input bit lb,
                         output logic [15:0] pre, output logic [15:0] val,
                         output logic [15:0] post, output logic [15:0] e);
    model_read(a, ub, lb, e);
    bus1.sram_addr = a;
    bus1.sram_control = ctl(1'b1, 1'b0, ub, lb);
    tb_drv = 1'b0;
    step(); pre = data1;
    step(); val = data1;
    bus_idle();
    step(); post = data1;
  endtask

  task automatic reset_pulse();
    bus_idle();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    exp_wc = 0;
    exp_err = 0;
  endtask

  task automatic test_reset();
    bus1.sram_addr = '0;
    reset_pulse();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
    total++; if (wc1 !== 16'd0) begin bad++; $display("FAIL reset_wc got=%h want=0000", wc1); end
    total++; if (err1 !== 8'd0) begin bad++; $display("FAIL reset_err got=%h want=00", err1); end
    total++; if (data1 !== 16'hFFFF) begin bad++; $display("FAIL reset_bus got=%h want=released", data1); end
  endtask

  task automatic test_basic();
    logic [15:0] pre, val, post, e;
    bus1.sram_addr = 18'h005;
    bus1.sram_control = ctl(1'b0, 1'b1, 1'b1, 1'b1);
    tb_drv = 1'b1;
    tb_wdata = 16'h1234;
    step();
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL busy_write got=%b want=1", busy1); end
    step(); step();
    bus_idle();
    step();
    model_write(18'h005, 16'h1234, 1'b1, 1'b1);
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b want=0", busy1); end
    total++; if (wc1 !== 16'(exp_wc)) begin bad++; $display("FAIL basic_wc got=%h want=%h", wc1, 16'(exp_wc)); end
    do_read(18'h005, 1'b1, 1'b1, pre, val, post, e);
    total++; if (pre !== 16'hFFFF) begin bad++; $display("FAIL basic_pre got=%h want=released", pre); end
    total++; if (val !== 16'h1234) begin bad++; $display("FAIL basic_rd got=%h want=1234", val); end
    total++; if (post !== 16'hFFFF) begin bad++; $display("FAIL basic_post got=%h want=released", post); end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] pre, val, post, e;
    do_write(18'h010, 16'h1111, 1'b1, 1'b1, 1);
    do_write(18'h010, 16'hABCD, 1'b1, 1'b0, 2);
    do_read(18'h010, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL lane_ub_write got=%h want=%h", val, e); end
    do_read(18'h010, 1'b0, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL lane_lb_read got=%h want=%h", val, e); end
  endtask

  task automatic test_oe_we();
    logic [15:0] pre, val, post, e;
    bus1.sram_addr = 18'h020;
    bus1.sram_control = ctl(1'b1, 1'b1, 1'b1, 1'b1);
    tb_drv = 1'b1;
    tb_wdata = 16'h5A5A;
    step(); step();
    bus_idle();
    step();
    bump_err(2);
    model_write(18'h020, 16'h5A5A, 1'b1, 1'b1);
    total++; if (err1 !== 8'(exp_err)) begin bad++; $display("FAIL oewe_err got=%h want=%h", err1, 8'(exp_err)); end
    total++; if (wc1 !== 16'(exp_wc)) begin bad++; $display("FAIL oewe_wc got=%h want=%h", wc1, 16'(exp_wc)); end
    do_read(18'h020, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL oewe_rd got=%h want=%h", val, e); end
  endtask

  task automatic test_latency3();
    logic [15:0] e;
    do_write(18'h033, 16'h3C3C, 1'b1, 1'b1, 1);
    model_read(18'h033, 1'b1, 1'b1, e);
    bus1.sram_addr = 18'h033;
    bus1.sram_control = ctl(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      total++; if (data3 !== 16'hFFFF) begin bad++; $display("FAIL lat3_early%0d got=%h want=released", k, data3); end
      step();
    end
    total++; if (data3 !== e) begin bad++; $display("FAIL lat3_data got=%h want=%h", data3, e); end
    bus_idle();
    step();
  endtask

  task automatic test_random();
    int a;
    bit ub, lb;
    logic [15:0] d, pre, val, post, e;
    for (int i = 0; i < 48; i++) begin
      a = 32'h100 + int'($urandom_range(0, 15));
      if (mm.exists(a) && $urandom_range(0, 1) == 1) begin
        ub = 1'($urandom);
        lb = 1'($urandom);
        do_read(18'(a), ub, lb, pre, val, post, e);
        total++; if (val !== e) begin bad++; $display("FAIL rand_rd a=%h got=%h want=%h", a, val, e); end
      end else begin
        ub = mm.exists(a) ? 1'($urandom) : 1'b1;
        lb = mm.exists(a) ? 1'($urandom) : 1'b1;
        d = 16'($urandom_range(0, 32'hFFFE));
        do_write(18'(a), d, ub, lb, int'($urandom_range(1, 3)));
      end
    end
    total++; if (wc1 !== 16'(exp_wc)) begin bad++; $display("FAIL rand_wc got=%h want=%h", wc1, 16'(exp_wc)); end
    total++; if (err1 !== 8'(exp_err)) begin bad++; $display("FAIL rand_err got=%h want=%h", err1, 8'(exp_err)); end
  endtask

  task automatic test_addr_change();
    logic [15:0] pre, val, post, e;
    bus1.sram_addr = 18'h040;
    bus1.sram_control = ctl(1'b0, 1'b1, 1'b1, 1'b1);
    tb_drv = 1'b1;
    tb_wdata = 16'h4040;
    step();
    bus1.sram_addr = 18'h041;
    tb_wdata = 16'h4141;
    step();
    bus_idle();
    step();
    model_write(18'h040, 16'h4040, 1'b1, 1'b1);
    model_write(18'h041, 16'h4141, 1'b1, 1'b1);
    bump_err(1);
    total++; if (err1 !== 8'(exp_err)) begin bad++; $display("FAIL move_err got=%h want=%h", err1, 8'(exp_err)); end
    do_read(18'h040, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL move_old got=%h want=%h", val, e); end
    do_read(18'h041, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL move_new got=%h want=%h", val, e); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] pre, val, post, e;
    model_read(18'h005, 1'b1, 1'b1, e);
    bus1.sram_addr = 18'h005;
    bus1.sram_control = ctl(1'b1, 1'b0, 1'b1, 1'b1);
    step(); step();
    total++; if (data1 !== e) begin bad++; $display("FAIL mid_rd_driven got=%h want=%h", data1, e); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (data1 !== 16'hFFFF) begin bad++; $display("FAIL mid_rd_release got=%h want=released", data1); end
    total++; if (wc1 !== 16'd0) begin bad++; $display("FAIL mid_rd_wc got=%h want=0000", wc1); end
    total++; if (err1 !== 8'd0) begin bad++; $display("FAIL mid_rd_err got=%h want=00", err1); end
    bus_idle();
    #2 reset_n = 1'b1;
    step();
    exp_wc = 0;
    exp_err = 0;
    bus1.sram_addr = 18'h005;
    bus1.sram_control = ctl(1'b0, 1'b1, 1'b1, 1'b1);
    tb_drv = 1'b1;
    tb_wdata = 16'h7777;
    step(); step();
    #3 reset_n = 1'b0;
    bus_idle();
    #3 reset_n = 1'b1;
    step();
    do_read(18'h005, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL mid_wr_mem got=%h want=%h", val, e); end
    total++; if (wc1 !== 16'd0) begin bad++; $display("FAIL mid_wr_wc got=%h want=0000", wc1); end
  endtask

  task automatic test_range();
    logic [15:0] pre, val, post, e;
    do_write(18'h01005, 16'hBEEF, 1'b1, 1'b1, 1);
    total++; if (err1 !== 8'(exp_err)) begin bad++; $display("FAIL range_wr_err got=%h want=%h", err1, 8'(exp_err)); end
    total++; if (wc1 !== 16'(exp_wc)) begin bad++; $display("FAIL range_wr_wc got=%h want=%h", wc1, 16'(exp_wc)); end
    do_read(18'h01005, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL range_rd_hi got=%h want=%h", val, e); end
    do_read(18'h005, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL range_rd_lo got=%h want=%h", val, e); end
    total++; if (err1 !== 8'(exp_err)) begin bad++; $display("FAIL range_err got=%h want=%h", err1, 8'(exp_err)); end
  endtask

  task automatic test_saturate();
    reset_pulse();
    bus1.sram_addr = 18'h050;
    bus1.sram_control = ctl(1'b1, 1'b1, 1'b1, 1'b1);
    tb_drv = 1'b1;
    tb_wdata = 16'h5050;
    for (int i = 1; i <= 300; i++) begin
      step();
      bump_err(1);
      if (i == 254 || i == 255 || i == 300) begin
        total++; if (err1 !== 8'(exp_err)) begin bad++; $display("FAIL sat_err%0d got=%h want=%h", i, err1, 8'(exp_err)); end
      end
    end
    bus_idle();
    step();
    model_write(18'h050, 16'h5050, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    logic [17:0] a, pa;
    logic [15:0] d, pd, pre, val, post, e;
    reset_pulse();
    bus1.sram_control = ctl(1'b0, 1'b1, 1'b1, 1'b1);
    tb_drv = 1'b1;
    pa = '0;
    pd = '0;
    for (int i = 0; i < 65536; i++) begin
      a = 18'(i % 4096);
      d = 16'(i) ^ 16'h5A5A;
      bus1.sram_addr = a;
      tb_wdata = d;
      step();
      if (i > 0) begin
        model_write(pa, pd, 1'b1, 1'b1);
        bump_err(1);
      end
      pa = a;
      pd = d;
    end
    total++; if (wc1 !== 16'(exp_wc)) begin bad++; $display("FAIL wrap_pre got=%h want=%h", wc1, 16'(exp_wc)); end
    bus_idle();
    step();
    model_write(pa, pd, 1'b1, 1'b1);
    total++; if (wc1 !== 16'(exp_wc)) begin bad++; $display("FAIL wrap_zero got=%h want=%h", wc1, 16'(exp_wc)); end
    total++; if (err1 !== 8'(exp_err)) begin bad++; $display("FAIL wrap_err got=%h want=%h", err1, 8'(exp_err)); end
    do_read(18'hFFF, 1'b1, 1'b1, pre, val, post, e);
    total++; if (val !== e) begin bad++; $display("FAIL wrap_rd got=%h want=%h", val, e); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    test_reset();
    test_basic();
    test_byte_lanes();
    test_oe_we();
    test_latency3();
    test_random();
    test_addr_change();
    test_reset_mid();
    test_range();
    test_saturate();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
